// File: rtl/fsm_calendar.sv
// Calendar date keeper (2000-2099): advances day/month/year on the midnight new_day pulse
// and loads validated dates over a set handshake. Define CAL_WEEKDAY_EN to add the weekday register.
module fsm_calendar #(
    parameter int unsigned RESET_YEAR    = 0,
    parameter int unsigned RESET_WEEKDAY = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_day,
    input  logic       set_req,
    input  logic [4:0] set_day,
    input  logic [3:0] set_month,
    input  logic [6:0] set_year,
    input  logic [2:0] set_weekday,
    output logic       set_ack,
    output logic       set_err,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic [2:0] weekday,
    output logic       new_month,
    output logic       new_year
);

    localparam logic [6:0] RST_YEAR = (RESET_YEAR > 99) ? 7'd0 : 7'(RESET_YEAR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_RESP,
        S_WAIT_REL
    } set_state_e;

    set_state_e state_q, state_d;

    logic       pending_q, pending_d;
    logic       capture, load, reject, apply_day;
    logic       cap_valid_q, cap_ok;
    logic [4:0] cap_day;
    logic [3:0] cap_month;
    logic [6:0] cap_year;

    logic [4:0] dim_cur;
    logic       end_of_month, end_of_year;
    logic [4:0] next_day;
    logic [3:0] next_month;
    logic [6:0] next_year;

    // Leap rule year%4==0 is exact over 2000-2099 because 2000 is a leap year.
    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Set handshake FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        capture   = 1'b0;
        load      = 1'b0;
        reject    = 1'b0;
        apply_day = 1'b0;
        case (state_q)
            S_IDLE: begin
                apply_day = new_day;
                if (set_req) begin
                    capture = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                pending_d = pending_q | new_day;
                state_d   = S_RESP;
            end
            S_RESP: begin
                pending_d = pending_q | new_day;
                load      = cap_valid_q;
                reject    = ~cap_valid_q;
                state_d   = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                // A midnight held over the load is applied on top of the new date.
                apply_day = new_day | pending_q;
                pending_d = 1'b0;
                if (!set_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Optional weekday register
    // ------------------------------------------------------------------
`ifdef CAL_WEEKDAY_EN
    localparam logic [2:0] RST_WDAY = (RESET_WEEKDAY > 6) ? 3'd0 : 3'(RESET_WEEKDAY);

    logic [2:0] cap_weekday;
    logic [2:0] weekday_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_weekday <= 3'd0;
            weekday_q   <= RST_WDAY;
        end else begin
            if (capture) cap_weekday <= set_weekday;
            if (load) begin
                weekday_q <= cap_weekday;
            end else if (apply_day) begin
                weekday_q <= (weekday_q == 3'd6) ? 3'd0 : weekday_q + 3'd1;
            end
        end
    end

    assign weekday = weekday_q;
`else
    localparam logic [2:0] UNUSED_RESET_WEEKDAY = 3'(RESET_WEEKDAY);

    logic unused_set_weekday;
    assign unused_set_weekday = ^set_weekday;
    assign weekday            = 3'd0;
`endif

    // ------------------------------------------------------------------
    // Validation of the captured fields
    // ------------------------------------------------------------------
    always_comb begin
        cap_ok = (cap_month >= 4'd1) && (cap_month <= 4'd12) &&
                 (cap_day >= 5'd1) && (cap_day <= days_in_month(cap_month, cap_year)) &&
                 (cap_year <= 7'd99);
`ifdef CAL_WEEKDAY_EN
        if (cap_weekday > 3'd6) cap_ok = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Date advance
    // ------------------------------------------------------------------
    always_comb begin
        dim_cur      = days_in_month(month, year);
        end_of_month = (day == dim_cur);
        end_of_year  = end_of_month && (month == 4'd12);
        next_day     = end_of_month ? 5'd1 : day + 5'd1;
        next_month   = month;
        next_year    = year;
        if (end_of_month) next_month = end_of_year ? 4'd1 : month + 4'd1;
        if (end_of_year)  next_year  = (year == 7'd99) ? 7'd0 : year + 7'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_day     <= 5'd1;
            cap_month   <= 4'd1;
            cap_year    <= 7'd0;
            cap_valid_q <= 1'b0;
            day         <= 5'd1;
            month       <= 4'd1;
            year        <= RST_YEAR;
            set_ack     <= 1'b0;
            set_err     <= 1'b0;
            new_month   <= 1'b0;
            new_year    <= 1'b0;
        end else begin
            set_ack   <= load;
            set_err   <= reject;
            new_month <= 1'b0;
            new_year  <= 1'b0;
            if (capture) begin
                cap_day   <= set_day;
                cap_month <= set_month;
                cap_year  <= set_year;
            end
            if (state_q == S_CHECK) cap_valid_q <= cap_ok;
            if (load) begin
                day   <= cap_day;
                month <= cap_month;
                year  <= cap_year;
            end else if (apply_day) begin
                day       <= next_day;
                month     <= next_month;
                year      <= next_year;
                new_month <= end_of_month;
                new_year  <= end_of_year;
            end
        end
    end

endmodule

// File: tb/tb_fsm_calendar.sv
// Self-checking bench for fsm_calendar: directed calendar corners plus randomized sets and
// midnights, compared against a date-arithmetic reference model. Honours CAL_WEEKDAY_EN.
module tb_fsm_calendar;

`ifdef CAL_WEEKDAY_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       new_day = 1'b0;
    logic       set_req = 1'b0;
    logic [4:0] set_day = '0;
    logic [3:0] set_month = '0;
    logic [6:0] set_year = '0;
    logic [2:0] set_weekday = '0;
    logic       set_ack, set_err, new_month, new_year;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic [2:0] weekday;

    int checks = 0;
    int errors = 0;

    // Reference model state: a plain calendar date.
    int m_day, m_month, m_year, m_wd;

    fsm_calendar #(.RESET_YEAR(0), .RESET_WEEKDAY(5)) dut (
        .clk(clk), .reset(reset), .new_day(new_day), .set_req(set_req),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .set_weekday(set_weekday), .set_ack(set_ack), .set_err(set_err),
        .day(day), .month(month), .year(year), .weekday(weekday),
        .new_month(new_month), .new_year(new_year)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_dim(input int m, input int y);
        int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m < 1 || m > 12) return 0;
        if (m == 2 && (y % 4) == 0) return 29;
        return tbl[m-1];
    endfunction

    function automatic bit model_valid(input int d, input int m, input int y, input int wd);
        if (m < 1 || m > 12) return 1'b0;
        if (d < 1 || d > model_dim(m, y)) return 1'b0;
        if (y > 99) return 1'b0;
        if (WD_EN && wd > 6) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_day = 1; m_month = 1; m_year = 0; m_wd = 5;
    endtask

    task automatic model_new_day(output bit nm, output bit ny);
        nm = 1'b0;
        ny = 1'b0;
        m_wd = (m_wd + 1) % 7;
        if (m_day < model_dim(m_month, m_year)) begin
            m_day++;
        end else begin
            m_day = 1;
            nm = 1'b1;
            if (m_month == 12) begin
                m_month = 1;
                ny = 1'b1;
                m_year = (m_year + 1) % 100;
            end else begin
                m_month++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_date(input string tag);
        check({tag, "_day"}, 32'(day), 32'(m_day));
        check({tag, "_month"}, 32'(month), 32'(m_month));
        check({tag, "_year"}, 32'(year), 32'(m_year));
        check({tag, "_weekday"}, 32'(weekday), WD_EN ? 32'(m_wd) : 32'd0);
    endtask

    // Full set transaction; the handshake drops set_req right after the response.
    task automatic do_set(input string tag, input int d, input int m, input int y, input int wd);
        bit ok;
        ok = model_valid(d, m, y, wd);
        set_day = 5'(d); set_month = 4'(m); set_year = 7'(y); set_weekday = 3'(wd);
        set_req = 1'b1;
        step();
        step();
        check({tag, "_early_ack"}, 32'(set_ack | set_err), 32'd0);
        step();
        if (ok) begin
            m_day = d; m_month = m; m_year = y; m_wd = wd;
        end
        check({tag, "_ack"}, 32'(set_ack), 32'(ok));
        check({tag, "_err"}, 32'(set_err), 32'(!ok));
        check_date(tag);
        set_req = 1'b0;
        step();
        check({tag, "_pulse_end"}, 32'(set_ack | set_err), 32'd0);
        step();
    endtask

    task automatic pulse_day(input string tag);
        bit nm, ny;
        new_day = 1'b1;
        step();
        new_day = 1'b0;
        model_new_day(nm, ny);
        check_date(tag);
        check({tag, "_new_month"}, 32'(new_month), 32'(nm));
        check({tag, "_new_year"}, 32'(new_year), 32'(ny));
        step();
        check({tag, "_pulse_end"}, 32'(new_month | new_year), 32'd0);
    endtask

    initial begin
        int acks, errs, n;

        // Reset held for 5 cycles.
        reset = 1'b0;
        repeat (5) step();
        model_reset();
        check_date("in_reset");
        reset = 1'b1;
        step();
        check_date("reset");
        check("reset_pulses", 32'({set_ack, set_err, new_month, new_year}), 32'd0);

        // Month, leap and year boundaries.
        do_set("set_jan31", 31, 1, 23, 2);
        pulse_day("jan31_23");
        do_set("set_feb28_23", 28, 2, 23, 1);
        pulse_day("feb28_23");
        do_set("set_feb28_24", 28, 2, 24, 2);
        pulse_day("feb28_24");
        pulse_day("feb29_24");
        do_set("set_dec31_99", 31, 12, 99, 6);
        pulse_day("dec31_99");

        // Invalid then valid set.
        do_set("set_apr31", 31, 4, 30, 0);
        do_set("set_jun15", 15, 6, 30, 3);
        do_set("set_bad_month", 10, 13, 30, 3);
        do_set("set_bad_year", 10, 5, 100, 3);
        do_set("set_feb29_odd", 29, 2, 25, 3);
        do_set("set_bad_wd", 10, 5, 30, 7);

        // set_req held for 10 cycles produces exactly one ack.
        set_day = 5'd10; set_month = 4'd10; set_year = 7'd10; set_weekday = 3'd4;
        set_req = 1'b1;
        acks = 0;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            acks += int'(set_ack);
            errs += int'(set_err);
        end
        set_req = 1'b0;
        check("hold_acks", 32'(acks), 32'd1);
        check("hold_errs", 32'(errs), 32'd0);
        m_day = 10; m_month = 10; m_year = 10; m_wd = 4;
        step();
        step();
        check_date("hold");

        // new_day during CHECK is held and applied the cycle after the load.
        set_day = 5'd30; set_month = 4'd6; set_year = 7'd30; set_weekday = 3'd2;
        set_req = 1'b1;
        step();
        new_day = 1'b1;
        step();
        new_day = 1'b0;
        step();
        m_day = 30; m_month = 6; m_year = 30; m_wd = 2;
        check("pend_ack", 32'(set_ack), 32'd1);
        check_date("pend_load");
        step();
        m_day = 1; m_month = 7; m_wd = 3;
        check_date("pend_apply");
        check("pend_new_month", 32'(new_month), 32'd1);
        check("pend_ack_end", 32'(set_ack), 32'd0);
        set_req = 1'b0;
        step();
        step();

        // Reset mid-handshake with a pending new_day.
        set_day = 5'd5; set_month = 4'd5; set_year = 7'd55; set_weekday = 3'd1;
        set_req = 1'b1;
        step();
        new_day = 1'b1;
        step();
        new_day = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_date("mid_reset_async");
        check("mid_reset_ack", 32'(set_ack | set_err), 32'd0);
        step();
        set_req = 1'b0;
        step();
        reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            acks += int'(set_ack | set_err | new_month);
        end
        check("mid_reset_no_resp", 32'(acks), 32'd0);
        check_date("mid_reset_after");

        // Randomized sets (valid and raw) followed by runs of midnights.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_set("rnd_raw", int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
            end else begin
                int rm, ry;
                rm = int'($urandom_range(1, 12));
                ry = int'($urandom_range(0, 99));
                do_set("rnd_set", int'($urandom_range(1, model_dim(rm, ry))), rm, ry,
                       int'($urandom_range(0, 6)));
            end
            n = int'($urandom_range(1, 40));
            for (int k = 0; k < n; k++) begin
                pulse_day("rnd_day");
                repeat ($urandom_range(0, 2)) step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
